regfile_write_arbiter: RTL
==========================

Name: regfile_write_arbiter

Overview:
- Shares the single register-file write port between the WB stage and a long-latency unit (LLU, e.g. the multi-cycle divider) returning results out of pipeline order.
- LLU results are queued in a small FIFO and drained into idle WB cycles.
- A starvation counter forces a one-cycle WB hold so queued results cannot wait forever.
- Sits between wb_stage and the register file; ID queries it for pending-write interlocks.

Parameters:
- DEPTH, 2, LLU result FIFO entries (power of two, 2..8).
- STARVE_LIMIT, 4, consecutive cycles a non-empty FIFO may go un-drained before wb_hold fires (1..15).

Ports:
- clock  input  1  core clock; all state on rising edge.
- reset  input  1  asynchronous, active-high reset.
- wb_write_enabled  input  1  WB stage requests a register write this cycle.
- wb_write_strobe  input  4  WB byte strobe.
- wb_write_address  input  5  WB destination register.
- wb_write_data  input  32  WB write data.
- wb_hold  output  1  WB write not granted this cycle; top level gates wb_allow_in with !wb_hold.
- llu_valid  input  1  LLU result available.
- llu_ready  output  1  FIFO can accept an LLU result.
- llu_address  input  5  LLU destination register.
- llu_data  input  32  LLU result (full-word write, strobe 4'b1111).
- query_address  input  5  ID source register to check.
- query_pending  output  1  a queued, unwritten FIFO entry targets query_address (address 0 never matches).
- rf_write_enabled  output  1  register-file write enable.
- rf_write_strobe  output  4  register-file byte strobe.
- rf_write_address  output  5  register-file address.
- rf_write_data  output  32  register-file data.
- fifo_count  output  $clog2(DEPTH)+1  occupied entries.

Behaviour:
- Reset is asynchronous, active-high. It clears FIFO pointers, count, the starvation counter and the hold flag, giving wb_hold=0, llu_ready=1, fifo_count=0, rf_write_enabled=0 and query_pending=0. Reset mid-operation discards queued entries; no write is issued in the reset cycle.
- FIFO push: push when llu_valid && llu_ready. llu_ready = (count != DEPTH), taken from registered count only. A push is refused when full even if a pop occurs in the same cycle.
- FIFO pop: pop on a FIFO grant. Pointers wrap modulo DEPTH.
- count updates: push-only increments, pop-only decrements, push+pop leaves count unchanged.
- Grant (combinational from inputs and registered state), one per cycle:
  1. If hold_flag=1: FIFO head granted (FIFO is non-empty by construction). wb_hold=1; WB write suppressed.
  2. Else if wb_write_enabled: WB granted; rf_* = wb_* passthrough.
  3. Else if count != 0: FIFO head granted with strobe 4'b1111.
  4. Else: rf_write_enabled=0.
- No-write outputs: when rf_write_enabled=0, rf_* data and address fields are don't-care; the bench checks them only when enabled.
- Same-cycle push and write: a newly pushed entry is never written in its push cycle (zero bypass). Minimum FIFO-to-RF latency is 1 cycle.
- Starvation counter (4 bits):
  - Increments each cycle count != 0 and no pop occurs.
  - Clears on any pop or when count == 0.
  - When the next value would equal STARVE_LIMIT, hold_flag is set for the next cycle and the counter clears.
- hold_flag behaviour:
  - Self-clears after exactly one cycle, so wb_hold is a single-cycle pulse per starvation event.
  - During hold the WB instruction stays resident because allow_in is gated, and re-issues its write next cycle. Register writes are idempotent, so nothing is lost.
- query_pending: OR over valid entries of (entry.address == query_address && query_address != 0).
  - An entry popping this cycle still reports pending.
  - An entry pushed this cycle is not yet visible.
  - ID must stall on query_pending to avoid WAW/RAW against queued results.
- Exception/eret flush does not touch the FIFO; queued results belong to already-committed instructions.

Test Plan:
- Reset, idle: hold reset 3 cycles, then release with no requests -> rf_write_enabled=0, llu_ready=1, fifo_count=0, wb_hold=0.
- WB priority: push LLU ($5, 0x1234) while WB writes ($3, 0xAAAA0000, strobe 4'b1111) every cycle -> RF gets $3 each cycle, fifo_count=1, query_pending=1 for $5. On the 4th stalled cycle (STARVE_LIMIT=4), the next cycle shows wb_hold=1 and RF gets $5/0x1234. The following cycle $3 is written again and wb_hold=0.
- Drain in idle: push two results ($7, $8) back-to-back with WB idle -> writes $7 then $8 in order, each one cycle after its push, fifo_count returns to 0.
- Full boundary (DEPTH=2): 3 consecutive llu_valid with WB busy -> llu_ready drops after the 2nd push. The 3rd is accepted only in the cycle after a pop frees space, never in the pop cycle itself.
- Query edge cases: queued $0 result -> query_pending=0 for query_address=0. Queue $9 -> query_pending=1 for 9, 0 for 10.
- Async reset mid-queue: reset asserted between clock edges with fifo_count=2 -> outputs clear immediately. After release there are no stale writes and fifo_count=0.

Source files
------------

// File: rtl/regfile_write_arbiter.sv
// Arbitrates the single register-file write port between the WB stage and queued
// long-latency-unit results, with a starvation hold so queued results always drain.
module regfile_write_arbiter #(
    parameter int DEPTH        = 2,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     wb_write_enabled,
    input  logic [3:0]               wb_write_strobe,
    input  logic [4:0]               wb_write_address,
    input  logic [31:0]              wb_write_data,
    output logic                     wb_hold,
    input  logic                     llu_valid,
    output logic                     llu_ready,
    input  logic [4:0]               llu_address,
    input  logic [31:0]              llu_data,
    input  logic [4:0]               query_address,
    output logic                     query_pending,
    output logic                     rf_write_enabled,
    output logic [3:0]               rf_write_strobe,
    output logic [4:0]               rf_write_address,
    output logic [31:0]              rf_write_data,
    output logic [$clog2(DEPTH):0]   fifo_count
);

    localparam int              AW    = $clog2(DEPTH);
    localparam logic [AW:0]     FULL  = (AW + 1)'(DEPTH);
    localparam logic [3:0]      LIMIT = 4'(STARVE_LIMIT);

    logic [4:0]    addr_mem [DEPTH];
    logic [31:0]   data_mem [DEPTH];
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;
    logic [AW:0]   count;
    logic [3:0]    starve;
    logic [3:0]    starve_next;
    logic          hold_flag;
    logic          push;
    logic          pop;
    logic          fifo_grant;
    logic          empty;
    logic [AW-1:0] offset;

    assign empty       = (count == '0);
    assign llu_ready   = (count != FULL);
    assign push        = llu_valid && llu_ready;
    assign pop         = fifo_grant;
    assign wb_hold     = hold_flag;
    assign fifo_count  = count;
    assign starve_next = starve + 4'd1;

    // Hold outranks WB; the FIFO is guaranteed non-empty whenever hold_flag is set.
    always_comb begin
        fifo_grant       = 1'b0;
        rf_write_enabled = 1'b0;
        rf_write_strobe  = '0;
        rf_write_address = '0;
        rf_write_data    = '0;
        if (!reset) begin
            if (hold_flag || (!wb_write_enabled && !empty)) begin
                fifo_grant       = 1'b1;
                rf_write_enabled = 1'b1;
                rf_write_strobe  = 4'b1111;
                rf_write_address = addr_mem[rd_ptr];
                rf_write_data    = data_mem[rd_ptr];
            end else if (wb_write_enabled) begin
                rf_write_enabled = 1'b1;
                rf_write_strobe  = wb_write_strobe;
                rf_write_address = wb_write_address;
                rf_write_data    = wb_write_data;
            end
        end
    end

    // An entry is live when its distance from the read pointer is below count.
    always_comb begin
        query_pending = 1'b0;
        offset        = '0;
        for (int i = 0; i < DEPTH; i++) begin
            offset = AW'(i) - rd_ptr;
            if (({1'b0, offset} < count) && (addr_mem[i] == query_address)
                && (query_address != 5'd0))
                query_pending = 1'b1;
        end
    end

    // NOTE: storage carries no reset; validity comes solely from the pointers and count.
    always_ff @(posedge clock) begin
        if (push) begin
            addr_mem[wr_ptr] <= llu_address;
            data_mem[wr_ptr] <= llu_data;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rd_ptr    <= '0;
            wr_ptr    <= '0;
            count     <= '0;
            starve    <= '0;
            hold_flag <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            hold_flag <= 1'b0;
            if (pop || empty) begin
                starve <= '0;
            end else if (starve_next == LIMIT) begin
                starve    <= '0;
                hold_flag <= 1'b1;
            end else begin
                starve <= starve_next;
            end
        end
    end

endmodule
